// File: rtl/key_edit_if.sv
// Key/edit bundle between the push-button front-end and its neighbours.
//   Raw keys  : KeyModeRaw, KeySetRaw, KeyPlusRaw, KeyMinusRaw (active-low, asynchronous)
//   Edit state: EditMode, EditPos[2:0], screen[1:0]
//   Strobes   : KeyPlus, KeyMinus (active-low one-cycle pulses), Blink
// master drives the raw keys and consumes the edit outputs; slave is the controller.
interface key_edit_if;
    logic       KeyModeRaw;
    logic       KeySetRaw;
    logic       KeyPlusRaw;
    logic       KeyMinusRaw;
    logic       EditMode;
    logic [2:0] EditPos;
    logic [1:0] screen;
    logic       KeyPlus;
    logic       KeyMinus;
    logic       Blink;

    modport master (
        output KeyModeRaw, KeySetRaw, KeyPlusRaw, KeyMinusRaw,
        input  EditMode, EditPos, screen, KeyPlus, KeyMinus, Blink
    );

    modport slave (
        input  KeyModeRaw, KeySetRaw, KeyPlusRaw, KeyMinusRaw,
        output EditMode, EditPos, screen, KeyPlus, KeyMinus, Blink
    );
endinterface

// File: rtl/key_edit_controller.sv
// Push-button front-end for the clock: synchronises and debounces four raw active-low keys
// and runs the IDLE/EDIT state machine that steers the time counters.
//   clk   : system clock
//   reset : synchronous, active-high
//   keys  : key_edit_if.slave -- raw keys in; EditMode, EditPos, screen, KeyPlus, KeyMinus and
//           Blink out. Every output comes straight from a flop.
module key_edit_controller #(
    parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,
    parameter int unsigned REPEAT_DELAY    = 25_000_000,
    parameter int unsigned REPEAT_PERIOD   = 10_000_000,
    parameter int unsigned BLINK_CYCLES    = 12_500_000
) (
    input logic       clk,
    input logic       reset,
    key_edit_if.slave keys
);

    localparam int unsigned RepMax = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int unsigned TimMax = (RepMax > BLINK_CYCLES) ? RepMax : BLINK_CYCLES;
    localparam int unsigned CntW   = $clog2(TimMax + 1);
    localparam int unsigned DbW    = $clog2(DEBOUNCE_CYCLES + 1);

    localparam logic [DbW-1:0]  DbMax       = DbW'(DEBOUNCE_CYCLES);
    localparam logic [CntW-1:0] RepDelayM1  = CntW'(REPEAT_DELAY - 1);
    localparam logic [CntW-1:0] RepPeriodM1 = CntW'(REPEAT_PERIOD - 1);
    localparam logic [CntW-1:0] BlinkM1     = CntW'(BLINK_CYCLES - 1);

    localparam int unsigned KMode  = 0;
    localparam int unsigned KSet   = 1;
    localparam int unsigned KPlus  = 2;
    localparam int unsigned KMinus = 3;

    typedef enum logic {
        StIdle,
        StEdit
    } state_e;

    // ------------------------------------------------------------------
    // Synchroniser and debouncer, one lane per key
    // ------------------------------------------------------------------
    logic [3:0]     raw;
    logic [3:0]     sync1_q, sync2_q;
    logic [3:0]     deb_q, deb_d, deb_prev_q;
    logic [DbW-1:0] db_cnt_q [4];
    logic [DbW-1:0] db_cnt_d [4];
    logic [3:0]     fall;

    assign raw = {keys.KeyMinusRaw, keys.KeyPlusRaw, keys.KeySetRaw, keys.KeyModeRaw};

    // The counter runs only while the synchronised level disagrees with the debounced one;
    // after DEBOUNCE_CYCLES disagreeing cycles the next disagreeing cycle commits the new level.
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            deb_d[i]    = deb_q[i];
            db_cnt_d[i] = '0;
            if (sync2_q[i] != deb_q[i]) begin
                if (db_cnt_q[i] == DbMax) begin
                    deb_d[i] = sync2_q[i];
                end else begin
                    db_cnt_d[i] = db_cnt_q[i] + DbW'(1);
                end
            end
        end
    end

    assign fall = deb_prev_q & ~deb_q;

    // ------------------------------------------------------------------
    // Edit FSM, auto-repeat and blink
    // ------------------------------------------------------------------
    state_e          state_q, state_d;
    logic [2:0]      pos_q, pos_d;
    logic [1:0]      screen_q, screen_d;
    logic            plus_q, plus_d;
    logic            minus_q, minus_d;
    logic            blink_q, blink_d;
    logic [CntW-1:0] blink_cnt_q, blink_cnt_d;

    // One repeat channel: it belongs to whichever of Plus/Minus last produced a press pulse.
    logic            rep_active_q, rep_active_d;
    logic            rep_minus_q, rep_minus_d;
    logic            rep_first_q, rep_first_d;
    logic [CntW-1:0] rep_cnt_q, rep_cnt_d;

    logic rep_held, rep_match, rep_due;
    logic ev_set, ev_mode, ev_plus, ev_minus;
    logic arm_plus, arm_minus;

    always_comb begin
        rep_held  = rep_minus_q ? ~deb_q[KMinus] : ~deb_q[KPlus];
        rep_match = (rep_cnt_q == (rep_first_q ? RepDelayM1 : RepPeriodM1));
        rep_due   = (state_q == StEdit) && rep_active_q && rep_held && rep_match;

        // Repeat pulses compete at the priority of their own key.
        ev_set   = fall[KSet];
        ev_mode  = fall[KMode];
        ev_plus  = fall[KPlus]  | (rep_due & ~rep_minus_q);
        ev_minus = fall[KMinus] | (rep_due &  rep_minus_q);

        state_d     = state_q;
        pos_d       = pos_q;
        screen_d    = screen_q;
        plus_d      = 1'b1;
        minus_d     = 1'b1;
        blink_d     = blink_q;
        blink_cnt_d = blink_cnt_q;
        arm_plus    = 1'b0;
        arm_minus   = 1'b0;

        case (state_q)
            StIdle: begin
                blink_d     = 1'b0;
                blink_cnt_d = '0;
                if (ev_set) begin
                    state_d = StEdit;
                    pos_d   = 3'd5;
                    blink_d = 1'b1;
                end else if (ev_mode) begin
                    screen_d = (screen_q == 2'd2) ? 2'd0 : screen_q + 2'd1;
                end
            end
            StEdit: begin
                if (blink_cnt_q == BlinkM1) begin
                    blink_d     = ~blink_q;
                    blink_cnt_d = '0;
                end else begin
                    blink_cnt_d = blink_cnt_q + CntW'(1);
                end

                if (ev_set) begin
                    blink_cnt_d = '0;
                    if (pos_q == 3'd0) begin
                        state_d = StIdle;
                        pos_d   = 3'd5;
                        blink_d = 1'b0;
                    end else begin
                        pos_d   = pos_q - 3'd1;
                        blink_d = 1'b1;
                    end
                end else if (ev_mode) begin
                    state_d     = StIdle;
                    pos_d       = 3'd5;
                    blink_d     = 1'b0;
                    blink_cnt_d = '0;
                end else if (ev_plus) begin
                    plus_d      = 1'b0;
                    blink_d     = 1'b1;
                    blink_cnt_d = '0;
                    arm_plus    = fall[KPlus];
                end else if (ev_minus) begin
                    minus_d     = 1'b0;
                    blink_d     = 1'b1;
                    blink_cnt_d = '0;
                    arm_minus   = fall[KMinus];
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        rep_active_d = rep_active_q;
        rep_minus_d  = rep_minus_q;
        rep_first_d  = rep_first_q;
        rep_cnt_d    = rep_cnt_q;
        if (arm_plus || arm_minus) begin
            rep_active_d = 1'b1;
            rep_minus_d  = arm_minus;
            rep_first_d  = 1'b1;
            rep_cnt_d    = '0;
        end else if (state_q != StEdit || state_d != StEdit || !rep_held) begin
            rep_active_d = 1'b0;
            rep_first_d  = 1'b0;
            rep_cnt_d    = '0;
        end else if (rep_active_q) begin
            // The schedule advances even if a higher-priority event swallowed this pulse.
            if (rep_match) begin
                rep_first_d = 1'b0;
                rep_cnt_d   = '0;
            end else begin
                rep_cnt_d = rep_cnt_q + CntW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q      <= '1;
            sync2_q      <= '1;
            deb_q        <= '1;
            deb_prev_q   <= '1;
            for (int i = 0; i < 4; i++) begin
                db_cnt_q[i] <= '0;
            end
            state_q      <= StIdle;
            pos_q        <= 3'd5;
            screen_q     <= 2'd0;
            plus_q       <= 1'b1;
            minus_q      <= 1'b1;
            blink_q      <= 1'b0;
            blink_cnt_q  <= '0;
            rep_active_q <= 1'b0;
            rep_minus_q  <= 1'b0;
            rep_first_q  <= 1'b0;
            rep_cnt_q    <= '0;
        end else begin
            sync1_q      <= raw;
            sync2_q      <= sync1_q;
            deb_q        <= deb_d;
            deb_prev_q   <= deb_q;
            for (int i = 0; i < 4; i++) begin
                db_cnt_q[i] <= db_cnt_d[i];
            end
            state_q      <= state_d;
            pos_q        <= pos_d;
            screen_q     <= screen_d;
            plus_q       <= plus_d;
            minus_q      <= minus_d;
            blink_q      <= blink_d;
            blink_cnt_q  <= blink_cnt_d;
            rep_active_q <= rep_active_d;
            rep_minus_q  <= rep_minus_d;
            rep_first_q  <= rep_first_d;
            rep_cnt_q    <= rep_cnt_d;
        end
    end

    assign keys.EditMode = (state_q == StEdit);
    assign keys.EditPos  = pos_q;
    assign keys.screen   = screen_q;
    assign keys.KeyPlus  = plus_q;
    assign keys.KeyMinus = minus_q;
    assign keys.Blink    = blink_q;

endmodule

// File: tb/tb_key_edit_controller.sv
// Self-checking bench for key_edit_controller with small timing parameters. A behavioural
// model computes every expected output from the key history and event timestamps.
module tb_key_edit_controller;

    localparam int D    = 4;
    localparam int RD   = 20;
    localparam int RP   = 8;
    localparam int BC   = 10;
    localparam int HMAX = 8192;

    logic clk;
    logic reset;
    key_edit_if bus ();

    key_edit_controller #(
        .DEBOUNCE_CYCLES (D),
        .REPEAT_DELAY    (RD),
        .REPEAT_PERIOD   (RP),
        .BLINK_CYCLES    (BC)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .keys  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Stimulus levels (keys: 0 mode, 1 set, 2 plus, 3 minus)
    bit r_reset;
    bit r_key [4];

    // Reference model state
    int t          = 0;
    int last_reset = -1;
    bit hist [4][HMAX];
    bit m_deb [4];
    bit m_fell [4];
    bit m_edit;
    int m_pos, m_screen;
    bit m_plus, m_minus;
    int m_force, rep_key, rep_t0;
    logic [8:0] exp_vec;
    int plus_lows, minus_lows;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    function automatic bit get_hist(input int k, input int s);
        if (s < 0 || s <= last_reset || s >= HMAX) return 1'b1;
        return hist[k][s];
    endfunction

    // Expected outputs after edge t, given the inputs that were applied before it.
    task automatic model_edge();
        bit held, due, pev, mev, armed, flip;
        int d;
        bit blink;
        if (r_reset) begin
            m_edit = 0; m_pos = 5; m_screen = 0; m_plus = 1; m_minus = 1;
            rep_key = 0; last_reset = t; m_force = t;
            for (int k = 0; k < 4; k++) begin
                m_deb[k] = 1; m_fell[k] = 0;
            end
            exp_vec = {1'b0, 3'd5, 2'd0, 1'b1, 1'b1, 1'b0};
            return;
        end
        held = (rep_key == 1) ? !m_deb[2] : (rep_key == 2) ? !m_deb[3] : 1'b0;
        d    = t - rep_t0;
        due  = m_edit && rep_key != 0 && held && (d == RD || (d > RD && ((d - RD) % RP) == 0));
        pev  = m_fell[2] || (due && rep_key == 1);
        mev  = m_fell[3] || (due && rep_key == 2);
        armed   = 0;
        m_plus  = 1;
        m_minus = 1;
        if (!m_edit) begin
            if (m_fell[1]) begin
                m_edit = 1; m_pos = 5; m_force = t;
            end else if (m_fell[0]) begin
                m_screen = (m_screen + 1) % 3;
            end
        end else begin
            if (m_fell[1]) begin
                if (m_pos == 0) begin
                    m_edit = 0; m_pos = 5;
                end else begin
                    m_pos = m_pos - 1; m_force = t;
                end
            end else if (m_fell[0]) begin
                m_edit = 0; m_pos = 5;
            end else if (pev) begin
                m_plus = 0; m_force = t;
                if (m_fell[2]) begin rep_key = 1; rep_t0 = t; armed = 1; end
            end else if (mev) begin
                m_minus = 0; m_force = t;
                if (m_fell[3]) begin rep_key = 2; rep_t0 = t; armed = 1; end
            end
        end
        if (!armed && (!m_edit || !held)) rep_key = 0;
        blink = m_edit && ((((t - m_force) / BC) % 2) == 0);
        exp_vec = {m_edit, 3'(m_pos), 2'(m_screen), m_plus, m_minus, blink};

        // Debounced level flips once the last D+1 synchronised samples all disagree.
        for (int k = 0; k < 4; k++) begin
            flip = 1;
            for (int s = t - 2 - D; s <= t - 2; s++) begin
                if (get_hist(k, s) == m_deb[k]) flip = 0;
            end
            m_fell[k] = 0;
            if (flip) begin
                m_deb[k]  = !m_deb[k];
                m_fell[k] = !m_deb[k];
            end
        end
    endtask

    task automatic cyc(input int n);
        logic [8:0] obs;
        for (int i = 0; i < n; i++) begin
            reset           = r_reset;
            bus.KeyModeRaw  = r_key[0];
            bus.KeySetRaw   = r_key[1];
            bus.KeyPlusRaw  = r_key[2];
            bus.KeyMinusRaw = r_key[3];
            if (t < HMAX) begin
                for (int k = 0; k < 4; k++) hist[k][t] = r_key[k];
            end
            @(posedge clk);
            model_edge();
            t++;
            @(negedge clk);
            obs = {bus.EditMode, bus.EditPos, bus.screen, bus.KeyPlus, bus.KeyMinus, bus.Blink};
            chk("cycle_outputs", 32'(obs), 32'(exp_vec));
            if (bus.KeyPlus === 1'b0) plus_lows++;
            if (bus.KeyMinus === 1'b0) minus_lows++;
        end
    endtask

    task automatic press(input int k, input int low, input int high);
        r_key[k] = 0;
        cyc(low);
        r_key[k] = 1;
        cyc(high);
    endtask

    initial begin
        #400_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int  dur [4];
        bit  found;

        for (int k = 0; k < 4; k++) r_key[k] = 1;
        r_reset = 1;
        cyc(3);
        chk("reset_state", 32'({bus.EditMode, bus.EditPos, bus.screen, bus.KeyPlus,
                                bus.KeyMinus, bus.Blink}), 32'(9'b0_101_00_11_0));

        // Set held from the first edge out of reset: EditMode rises at edge 7.
        r_reset  = 0;
        r_key[1] = 0;
        cyc(7);
        chk("edit_before_edge7", 32'(bus.EditMode), 32'd0);
        cyc(1);
        chk("edit_at_edge7", 32'({bus.EditMode, bus.EditPos, bus.Blink}), 32'(5'b1_101_1));
        r_key[1] = 1;
        cyc(8);
        for (int i = 0; i < 6; i++) begin
            press(1, 8, 8);
            chk("set_step_pos", 32'(bus.EditPos), (i < 5) ? 32'(4 - i) : 32'd5);
            chk("set_step_mode", 32'(bus.EditMode), (i < 5) ? 32'd1 : 32'd0);
        end

        // Bounce rejection on Plus, then one clean press.
        press(1, 8, 8);
        plus_lows = 0;
        for (int i = 0; i < 5; i++) begin
            r_key[2] = 0; cyc(3);
            r_key[2] = 1; cyc(3);
        end
        cyc(8);
        chk("bounce_no_pulse", 32'(plus_lows), 32'd0);
        press(2, 8, 8);
        chk("clean_plus_one_pulse", 32'(plus_lows), 32'd1);

        // Auto-repeat on Minus.
        minus_lows = 0;
        r_key[3] = 0; cyc(60);
        r_key[3] = 1; cyc(10);
        chk("repeat_pulses", 32'(minus_lows), 32'd6);
        cyc(20);
        chk("repeat_after_release", 32'(minus_lows), 32'd6);

        // Set and Plus fall together: Set wins, Plus dropped.
        plus_lows = 0;
        r_key[1] = 0; r_key[2] = 0; cyc(8);
        r_key[1] = 1; r_key[2] = 1; cyc(8);
        chk("prio_pos", 32'(bus.EditPos), 32'd4);
        chk("prio_no_plus", 32'(plus_lows), 32'd0);

        // Mode in EDIT leaves without touching screen.
        press(0, 8, 8);
        chk("mode_exit", 32'({bus.EditMode, bus.EditPos, bus.screen}), 32'(6'b0_101_00));

        // IDLE: Mode cycles screen, Plus ignored.
        for (int i = 0; i < 3; i++) begin
            press(0, 8, 8);
            chk("screen_step", 32'(bus.screen), 32'((i + 1) % 3));
        end
        plus_lows = 0;
        press(2, 8, 8);
        chk("idle_plus_ignored", 32'({plus_lows[3:0], bus.EditMode}), 32'd0);

        // Reset on the cycle KeyPlus is low, with Plus held through reset.
        press(1, 8, 8);
        r_key[2] = 0;
        found = 0;
        for (int i = 0; i < 20 && !found; i++) begin
            cyc(1);
            if (bus.KeyPlus === 1'b0) found = 1;
        end
        chk("plus_pulse_seen", 32'(found), 32'd1);
        r_reset = 1; cyc(1);
        chk("mid_reset_state", 32'({bus.EditMode, bus.EditPos, bus.screen, bus.KeyPlus,
                                    bus.KeyMinus, bus.Blink}), 32'(9'b0_101_00_11_0));
        r_reset   = 0;
        plus_lows = 0;
        cyc(20);
        press(1, 8, 30);
        chk("held_plus_no_pulse", 32'({plus_lows[3:0], bus.EditMode}), 32'd1);
        r_key[2] = 1; cyc(8);
        press(2, 8, 8);
        chk("repress_plus_pulse", 32'(plus_lows), 32'd1);

        // Randomised key activity with occasional reset.
        for (int k = 0; k < 4; k++) dur[k] = $urandom_range(1, 30);
        for (int c = 0; c < 2500; c++) begin
            for (int k = 0; k < 4; k++) begin
                dur[k]--;
                if (dur[k] <= 0) begin
                    r_key[k] = !r_key[k];
                    dur[k]   = (r_key[k] == 0) ? $urandom_range(1, 30) : $urandom_range(1, 40);
                end
            end
            r_reset = ($urandom_range(0, 499) == 0);
            cyc(1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
